// File: rtl/instr_encoder.sv
// instr_encoder: symbolic request -> 32-bit MIPS machine word, tagged with its
// word address and buffered in a small output FIFO.
// Optional feature macro: INSTR_ENCODER_LI_EN compiles in the `li` pseudo-op
// expansion (IDLE/EXPAND state machine). Without it, op 11 is illegal.
module instr_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_PC    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        err_illegal
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,
                         OP_SLL = 4'd3,  OP_JR  = 4'd4,  OP_ORI = 4'd5,
                         OP_LW  = 4'd6,  OP_SW  = 4'd7,  OP_BEQ = 4'd8,
                         OP_LUI = 4'd9,  OP_JAL = 4'd10;
`ifdef INSTR_ENCODER_LI_EN
  localparam logic [3:0] OP_LI  = 4'd11;
`endif

  localparam logic [5:0] OPC_ORI = 6'b001101, OPC_LW  = 6'b100011,
                         OPC_SW  = 6'b101011, OPC_BEQ = 6'b000100,
                         OPC_LUI = 6'b001111, OPC_JAL = 6'b000011;

  // FIFO storage and bookkeeping
  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   next_pc;

  logic        fifo_free, accept, pop, push;
  logic [31:0] push_word;
  logic [31:0] enc_word;
  logic        enc_legal;

  assign fifo_free = count < CW'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign accept    = req_valid && req_ready;
  assign out_instr = mem_instr[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];

`ifdef INSTR_ENCODER_LI_EN
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t      state, state_nx;
  logic        li_two;
  logic [4:0]  li_rt;
  logic [15:0] li_lo;
`endif

  // Field packing for the request currently on the input
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
`ifdef INSTR_ENCODER_LI_EN
    li_two    = 1'b0;
`endif
    case (req_op)
      OP_NOP: enc_word = '0;
      OP_ADD: enc_word = {6'b0, req_rs, req_rt, req_rd, req_shamt, 6'b100000};
      OP_SUB: enc_word = {6'b0, req_rs, req_rt, req_rd, req_shamt, 6'b100010};
      OP_SLL: enc_word = {6'b0, 5'd0, req_rt, req_rd, req_shamt, 6'b000000};
      OP_JR:  enc_word = {6'b0, req_rs, 15'd0, 6'b001000};
      OP_ORI: enc_word = {OPC_ORI, req_rs, req_rt, req_imm[15:0]};
      OP_LW:  enc_word = {OPC_LW,  req_rs, req_rt, req_imm[15:0]};
      OP_SW:  enc_word = {OPC_SW,  req_rs, req_rt, req_imm[15:0]};
      OP_BEQ: enc_word = {OPC_BEQ, req_rs, req_rt, req_imm[15:0]};
      OP_LUI: enc_word = {OPC_LUI, 5'd0, req_rt, req_imm[15:0]};
      OP_JAL: enc_word = {OPC_JAL, req_imm[25:0]};
`ifdef INSTR_ENCODER_LI_EN
      // Zero upper half -> single ori; otherwise lui first, ori only if low half nonzero
      OP_LI: begin
        if (req_imm[31:16] == 16'd0) begin
          enc_word = {OPC_ORI, 5'd0, req_rt, req_imm[15:0]};
        end else begin
          enc_word = {OPC_LUI, 5'd0, req_rt, req_imm[31:16]};
          li_two   = req_imm[15:0] != 16'd0;
        end
      end
`endif
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef INSTR_ENCODER_LI_EN
  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: EXPAND holds until the ori word finds a free slot
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && enc_legal && li_two) state_nx = EXPAND;
      EXPAND:  if (fifo_free) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: FIFO write select and request acceptance
  always_comb begin
    push      = 1'b0;
    push_word = enc_word;
    case (state)
      IDLE:    push = accept && enc_legal;
      EXPAND: begin
        push      = fifo_free;
        push_word = {OPC_ORI, li_rt, li_rt, li_lo};
      end
      default: push = 1'b0;
    endcase
  end

  assign req_ready = reset && (state == IDLE) && fifo_free;

  // Remember the li target and low half for the second word
  always_ff @(posedge clk) begin
    if (!reset) begin
      li_rt <= '0;
      li_lo <= '0;
    end else if (accept) begin
      li_rt <= req_rt;
      li_lo <= req_imm[15:0];
    end
  end
`else
  logic unused_imm;
  assign unused_imm = ^req_imm[31:26];

  // Only IDLE exists: every accepted legal op writes one word
  always_comb begin
    push      = accept && enc_legal;
    push_word = enc_word;
  end

  assign req_ready = reset && fifo_free;
`endif

  // Illegal-op pulse, one cycle after the accepting edge
  always_ff @(posedge clk) begin
    if (!reset) err_illegal <= 1'b0;
    else        err_illegal <= accept && !enc_legal;
  end

  // FIFO and address counter; storage cleared so the head reads 0 / BASE_PC out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      next_pc <= BASE_PC;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= BASE_PC;
      end
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= push_word;
        mem_pc[wr_ptr]    <= next_pc;
        wr_ptr            <= wr_ptr + AW'(1);
        next_pc           <= next_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the single-cycle MIPS datapath's test and boot flow: the inverse of the control decoder. Accepts symbolic instruction requests (op code, register fields, immediate) over a valid/ready handshake and emits 32-bit MIPS machine words, each tagged with its word address. Words are emitted through a small output FIFO. The `li` pseudo-instruction is expanded into one or two real instructions by an internal state machine. Feeds instruction-memory preload or a streaming instruction source.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `BASE_PC`, 32'h0000_3000: address assigned to the first emitted word.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low; reset takes effect when `reset` is 0 at a rising edge of `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: encoder can accept this cycle.
- `req_op` in 4: 0 nop, 1 add, 2 sub, 3 sll, 4 jr, 5 ori, 6 lw, 7 sw, 8 beq, 9 lui, 10 jal, 11 li; 12–15 illegal.
- `req_rs`, `req_rt`, `req_rd`, `req_shamt` in 5 each: register and shift-amount fields.
- `req_imm` in 32: `[15:0]` for I-type ops, `[25:0]` for `jal`, full 32 bits for `li`.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_instr` out 32: encoded word at the FIFO head.
- `out_pc` out 32: address of `out_instr`.
- `err_illegal` out 1: one-cycle pulse on an accepted illegal op.

## Operation
- Field packing is standard MIPS. R-type is `{000000, rs, rt, rd, shamt, funct}`:
  - add: funct 100000.
  - sub: funct 100010.
  - sll: rs forced to 0, funct 000000.
  - jr: rt, rd and shamt forced to 0, funct 001000.
- I-type is `{opc, rs, rt, imm16}`:
  - ori 001101, lw 100011, sw 101011, beq 000100.
  - lui 001111, with rs forced to 0.
- jal is `{000011, imm[25:0]}`. nop is 32'h0.
- `li rt, imm` expansion:
  - `imm[31:16]==0`: emits one word, `ori rt,$0,imm[15:0]`.
  - `imm[15:0]==0` (and upper half nonzero): emits one word, `lui rt,imm[31:16]`.
  - Otherwise: emits `lui rt,imm[31:16]` followed by `ori rt,rt,imm[15:0]`.
- FSM states:
  - IDLE: accept requests. A two-word `li` writes the `lui` word on accept, latches `rt` and the low half, then moves to EXPAND.
  - EXPAND: writes the `ori` word as soon as a FIFO slot is free, then returns to IDLE.
- `req_ready` = `reset`==1 AND state==IDLE AND FIFO count < `FIFO_DEPTH`. It has no combinational dependence on `out_ready`.
- Address counter `next_pc`:
  - Starts at `BASE_PC` and increments by 4 per word written into the FIFO.
  - Wraps modulo 2^32.
  - Each FIFO entry stores `{instr, pc}`.
- Illegal op:
  - The handshake completes normally.
  - No word is written and `next_pc` is unchanged.
  - `err_illegal` is asserted for exactly the next cycle.
- Unused input bits are ignored; register fields are taken as the 5-bit values given.

## Timing
- Reset values: `out_valid` 0, `out_instr` 0, `out_pc` `BASE_PC`, `err_illegal` 0, `req_ready` 0 while in reset. FIFO is empty, state is IDLE, `next_pc` = `BASE_PC`.
- Latency: a word accepted at edge N appears at the FIFO head with `out_valid`=1 after edge N if the FIFO was empty.
- `out_instr` and `out_pc` hold stable while `out_valid`=1 and `out_ready`=0.
- A pop happens when `out_valid` and `out_ready` are both 1. Push and pop in the same cycle keep the count unchanged.
- When full: `req_ready` is 0 even if a pop happens that cycle. It rises the cycle after the pop.
- `li` with two words:
  - `req_ready` drops for at least one cycle after accept.
  - If the FIFO has room, the `ori` word is written on the next edge, giving back-to-back PCs.
  - `req_ready` returns in the following cycle.
- Reset mid-EXPAND: the pending `ori` word is discarded, the FIFO is flushed, and `next_pc` returns to `BASE_PC`.
- Count wrap-around: FIFO pointers wrap modulo `FIFO_DEPTH`. The count never exceeds `FIFO_DEPTH`.

## Configuration
- `INSTR_ENCODER_LI_EN` defined: the `li` expansion and the EXPAND state are compiled in.
- `INSTR_ENCODER_LI_EN` not defined:
  - op 11 is treated as illegal (pulses `err_illegal`, writes no word).
  - The FSM is only IDLE, so `req_ready` depends only on FIFO count and reset.

## Test plan
- add rs=1 rt=2 rd=3 with `out_ready`=1 → `out_instr`=32'h00221820, `out_pc`=32'h3000, `out_valid` high the cycle after accept.
- li rt=8 imm=32'h12345678 → 32'h3C081234 at 32'h3000, then 32'h35085678 at 32'h3004. `req_ready` low for one cycle.
- li rt=8 imm=32'h000000FF → single word 32'h340800FF. Then jal imm=26'h0000C00 → 32'h0C000C00 at the next PC.
- `out_ready`=0, `FIFO_DEPTH`=4, push 4 nops → `req_ready`=0 after the 4th. Pop one → `req_ready`=1 the following cycle. PCs are 3000/3004/3008/300C, in order.
- op 15 accepted → `err_illegal` is a one-cycle pulse, no `out_valid`, and the next legal word still gets the PC that was next before the illegal op.
- li two-word request with `out_ready`=0 and FIFO 3/4 full, then `reset`=0 during EXPAND → `out_valid`=0 and the FIFO is empty. The first post-reset word gets `out_pc`=32'h3000.
